hls_task_sequencer: RTL and testbench

- Controller between a 32-bit input/output FIFO pair and one Vivado-HLS core using the ap_ctrl_hs handshake (ap_start/ap_ready/ap_done/ap_idle, one 32-bit scalar argument, one 32-bit ap_return).
- Pops one argument word per task from the input FIFO and drives it onto the core argument.
- Starts the core, captures ap_return on ap_done, and pushes the result to the output FIFO.
- Replaces hand-written per-core state machines in generated wrappers; guards against a hung core with a timeout.

---
 rtl/hls_task_sequencer.sv | 122 ++++++++++++
 tb/tb_hls_task_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_task_sequencer.sv
// Sequences one ap_ctrl_hs HLS core between an input and output FIFO:
// pop argument, start core, capture ap_return (or an error word on timeout), push result.
module hls_task_sequencer #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          TIMEOUT  = 65535,
  parameter logic [DATA_W-1:0]    ERR_WORD = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_empty,
  output logic              in_rd_en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_full,
  output logic              out_wr_en,
  output logic [DATA_W-1:0] out_data,
  output logic              ap_start,
  input  logic              ap_ready,
  input  logic              ap_done,
  input  logic              ap_idle,
  output logic [DATA_W-1:0] ap_arg,
  input  logic [DATA_W-1:0] ap_return,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       task_count,
  output logic [2:0]        state_dbg
);

  // Handshake: the input FIFO is read with a one-cycle strobe and its data is
  // valid the following cycle; the output FIFO is written with a one-cycle
  // strobe that is only raised while out_full is low; the core accepts its
  // argument on the cycle ap_start and ap_ready are both high, and ap_return
  // is only sampled while ap_done is high.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_POP       = 3'd1,
    S_LATCH     = 3'd2,
    S_START     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_PUSH      = 3'd5
  } state_t;

  // Abort fires on the cycle the counter holds TIMEOUT-1, i.e. the TIMEOUT-th WAIT_DONE cycle.
  localparam int unsigned    TO_LIM = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam int             CW     = (TO_LIM > 1) ? $clog2(TO_LIM + 1) : 1;
  localparam logic [CW-1:0]  TO_MAX = TO_LIM[CW-1:0];

  state_t              state;
  logic [CW-1:0]       wait_cnt;
  logic [DATA_W-1:0]   result;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == TO_MAX);
  assign in_rd_en    = (state == S_POP);
  assign out_wr_en   = (state == S_PUSH) && !out_full;
  assign out_data    = result;
  assign state_dbg   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      result      <= '0;
      ap_arg      <= '0;
      ap_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      task_count  <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!in_empty && ap_idle) begin
            state <= S_POP;
            busy  <= 1'b1;
          end
        end
        S_POP: state <= S_LATCH;
        S_LATCH: begin
          ap_arg   <= in_data;
          ap_start <= 1'b1;
          state    <= S_START;
        end
        S_START: begin
          if (ap_ready) begin
            ap_start <= 1'b0;
            if (ap_done) begin
              result <= ap_return;
              state  <= S_PUSH;
            end else begin
              wait_cnt <= '0;
              state    <= S_WAIT_DONE;
            end
          end
        end
        S_WAIT_DONE: begin
          // A real completion takes priority over a coincident expiry.
          if (ap_done) begin
            result <= ap_return;
            state  <= S_PUSH;
          end else if (timeout_hit) begin
            result      <= ERR_WORD;
            timeout_err <= 1'b1;
            state       <= S_PUSH;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_PUSH: begin
          if (!out_full) begin
            task_count <= task_count + 16'd1;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hls_task_sequencer.sv
// Bench for hls_task_sequencer: FIFO and ap_ctrl_hs core models, per-task expected
// results queued at issue time and checked by an independent output monitor.
module tb_hls_task_sequencer;
  localparam int          DW  = 32;
  localparam int          TO  = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic          clk;
  logic          rst_n;
  logic          in_empty;
  logic          in_rd_en;
  logic [DW-1:0] in_data;
  logic          out_full;
  logic          out_wr_en;
  logic [DW-1:0] out_data;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_done;
  logic          ap_idle;
  logic [DW-1:0] ap_arg;
  logic [DW-1:0] ap_return;
  logic          busy;
  logic          timeout_err;
  logic [15:0]   task_count;
  logic [2:0]    state_dbg;

  hls_task_sequencer #(.DATA_W(DW), .TIMEOUT(TO), .ERR_WORD(ERR)) dut (
    .clk(clk), .rst_n(rst_n), .in_empty(in_empty), .in_rd_en(in_rd_en), .in_data(in_data),
    .out_full(out_full), .out_wr_en(out_wr_en), .out_data(out_data),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_arg(ap_arg), .ap_return(ap_return), .busy(busy), .timeout_err(timeout_err),
    .task_count(task_count), .state_dbg(state_dbg)
  );

  typedef struct {
    logic [31:0] arg;
    logic [31:0] ret;
    bit          hang;      // core accepts but never completes
    bit          done_now;  // ap_done together with ap_ready
    int          rdy_dly;   // cycles of ap_start before ap_ready
    int          done_dly;  // WAIT_DONE cycles before ap_done
    int          gap;       // cycles busy after finishing
  } task_t;

  // kind: 0 plain, 1 hang, 2 plain + pop-to-push latency, 3 hang + timeout latency
  task_t         core_q[$];
  logic [31:0]   in_fifo[$];
  logic [DW-1:0] exp_q[$];
  int            kind_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt = 0;
  bit err_model = 0;
  int last_pop_cyc = 0;
  int wd_start = 0;
  bit wd_flag = 0;
  bit rnd_full = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input task_t t, input int kind);
    in_fifo.push_back(t.arg);
    core_q.push_back(t);
    exp_q.push_back(t.hang ? ERR : t.ret);
    kind_q.push_back(kind);
  endtask

  function automatic task_t mk(input logic [31:0] arg, input logic [31:0] ret, input bit hang,
                               input bit done_now, input int rdy, input int dd, input int gap);
    task_t t;
    t.arg = arg; t.ret = ret; t.hang = hang; t.done_now = done_now;
    t.rdy_dly = rdy; t.done_dly = dd; t.gap = gap;
    return t;
  endfunction

  task automatic drain(input string nm);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL %s_drain: got %0d pending results expected 0", nm, exp_q.size());
    end
  endtask

  // Input FIFO: read strobe sampled mid-cycle, data presented the next cycle.
  initial begin
    bit rd;
    in_empty = 1'b1;
    in_data  = '0;
    forever begin
      @(negedge clk);
      rd = in_rd_en;
      if (rd) check("rd_while_empty", 32'(in_empty), 32'd0);
      @(posedge clk);
      #1;
      if (rd && in_fifo.size() > 0) in_data = in_fifo.pop_front();
      in_empty = (in_fifo.size() == 0);
    end
  end

  // Random output back-pressure, only while enabled.
  initial begin
    forever begin
      tick();
      if (rnd_full) out_full = ($urandom_range(0, 2) == 0);
    end
  end

  // ap_ctrl_hs core model.
  initial begin
    task_t rec;
    int    n;
    ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b1; ap_return = $urandom;
    forever begin
      tick();
      if (rst_n && ap_start) begin
        if (core_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_start: got ap_start=1 expected 0");
          continue;
        end
        rec = core_q.pop_front();
        check("ap_arg", ap_arg, rec.arg);
        ap_idle = 1'b0;
        repeat (rec.rdy_dly) tick();
        ap_ready = 1'b1;
        if (rec.done_now) begin
          ap_done = 1'b1;
          ap_return = rec.ret;
        end
        if (rec.hang) begin
          wd_start = cyc + 1;
          wd_flag  = 1'b1;
        end
        tick();
        ap_ready = 1'b0; ap_done = 1'b0; ap_return = $urandom;
        if (!rec.done_now) begin
          if (rec.hang) begin
            n = 0;
            while (rst_n && n < 200) begin
              @(negedge clk);
              if (out_wr_en) break;
              n++;
            end
            tick();
          end else begin
            repeat (rec.done_dly) tick();
            ap_done = 1'b1; ap_return = rec.ret;
            tick();
            ap_done = 1'b0; ap_return = $urandom;
          end
        end
        repeat (rec.gap) tick();
        ap_idle = 1'b1;
      end
    end
  end

  // Output monitor: every write is matched against the oldest expected result.
  always @(negedge clk) begin
    logic [31:0] e;
    int k;
    if (rst_n) begin
      if (in_rd_en) last_pop_cyc = cyc;
      if (out_wr_en) begin
        check("wr_while_full", 32'(out_full), 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got %h expected no write", out_data);
        end else begin
          e = exp_q.pop_front();
          k = kind_q.pop_front();
          check("out_data", out_data, e);
          if (k == 1 || k == 3) err_model = 1'b1;
          check("timeout_err", 32'(timeout_err), 32'(err_model));
          check("task_count", 32'(task_count), 32'(16'(model_cnt)));
          model_cnt++;
          if (k == 2) check("pop_push_latency", 32'(cyc - last_pop_cyc), 32'd3);
          if (k == 3) check("timeout_latency", 32'(cyc - wd_start), 32'(TO));
        end
      end
    end
  end

  initial begin
    int n;
    logic [31:0] a;
    rst_n = 1'b0;
    out_full = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ap_start", 32'(ap_start), 32'd0);
    check("rst_rd_en", 32'(in_rd_en), 32'd0);
    check("rst_wr_en", 32'(out_wr_en), 32'd0);
    check("rst_task_count", 32'(task_count), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_ap_arg", ap_arg, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Single task: ready+done together five cycles after start.
    issue(mk(32'h10, 32'h20, 0, 1, 5, 0, 2), 0);
    drain("single");
    repeat (2) tick();
    check("single_count", 32'(task_count), 32'd1);
    check("single_busy", 32'(busy), 32'd0);

    // Combinational core: POP, LATCH, START, PUSH back to back.
    issue(mk(32'd7, 32'd7, 0, 1, 0, 0, 1), 2);
    drain("combo");

    // Back-pressure on the output FIFO.
    out_full = 1'b1;
    issue(mk(32'h1234, 32'hCAFE_0001, 0, 1, 0, 0, 0), 0);
    repeat (10) tick();
    check("bp_hold_data_a", out_data, 32'hCAFE_0001);
    repeat (14) tick();
    check("bp_hold_data_b", out_data, 32'hCAFE_0001);
    check("bp_no_write", 32'(exp_q.size()), 32'd1);
    out_full = 1'b0;
    @(negedge clk);
    check("bp_write_after_release", 32'(out_wr_en), 32'd1);
    drain("bp");

    // done arriving on the expiry cycle still delivers the real result.
    issue(mk(32'h33, 32'h0000_0777, 0, 0, 1, TO - 1, 1), 0);
    drain("expiry_tie");
    check("tie_no_err", 32'(timeout_err), 32'd0);

    // Hung core, then good tasks with sticky error flag.
    wd_flag = 1'b0;
    issue(mk(32'h44, 32'h0, 1, 0, 1, 0, 1), 3);
    issue(mk(32'h45, 32'h55, 0, 0, 0, 2, 0), 0);
    drain("timeout");
    check("timeout_sticky", 32'(timeout_err), 32'd1);

    // Burst with empty gaps and a busy core between tasks.
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      issue(mk(a, a ^ 32'h5A5A_5A5A, 0, 0, $urandom_range(0, 2), $urandom_range(0, 5),
               $urandom_range(2, 4)), 0);
      repeat ($urandom_range(2, 6)) tick();
    end
    drain("burst");

    // Randomized traffic with random output back-pressure.
    rnd_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0)
        issue(mk(a, 32'h0, 1, 0, $urandom_range(0, 3), 0, $urandom_range(0, 3)), 1);
      else
        issue(mk(a, $urandom, 0, $urandom_range(0, 1), $urandom_range(0, 3),
                 $urandom_range(0, TO - 1), $urandom_range(0, 3)), 0);
      repeat ($urandom_range(0, 12)) tick();
    end
    drain("random");
    rnd_full = 1'b0;
    tick();
    out_full = 1'b0;
    check("random_count", 32'(task_count), 32'(16'(model_cnt)));

    // Asynchronous reset in the middle of WAIT_DONE.
    wd_flag = 1'b0;
    issue(mk(32'h99, 32'h0, 1, 0, 0, 0, 1), 1);
    n = 0;
    while (!wd_flag && n < 200) begin
      tick();
      n++;
    end
    check("reset_reached_wait", 32'(wd_flag), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_task_count", 32'(task_count), 32'd0);
    check("arst_timeout_err", 32'(timeout_err), 32'd0);
    check("arst_ap_arg", ap_arg, 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_wr_en", 32'(out_wr_en), 32'd0);
    exp_q.delete();
    kind_q.delete();
    model_cnt = 0;
    err_model = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    issue(mk(32'hABCD, 32'h0BAD_F00D, 0, 1, 0, 0, 1), 2);
    drain("post_reset");
    repeat (2) tick();
    check("post_reset_count", 32'(task_count), 32'd1);
    check("post_reset_err", 32'(timeout_err), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
